// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with integrated hazard detection.
// Captures the decoded ID instruction for the EXE stage. It inserts bubbles on
// load-use hazards, and on every RAW hazard when forwarding is disabled. It
// holds all state during a memory stall and squashes the ID slot when a branch
// is taken.
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              forward_EN,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_two_src,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [8:0]        id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [36:0]       id_imm_fields,
    input  logic              mem_wb_en,
    input  logic [REG_W-1:0]  mem_dest,
    output logic              hazard,
    output logic              exe_valid,
    output logic [REG_W-1:0]  exe_src1,
    output logic [REG_W-1:0]  exe_src2,
    output logic [REG_W-1:0]  exe_dest,
    output logic [8:0]        exe_ctrl,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic [36:0]       exe_imm_fields,
    output logic [CNT_W-1:0]  stall_count
);

    // Control word layout: {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd[3:0]}
    localparam int CTRL_WB_EN    = 8;
    localparam int CTRL_MEM_R_EN = 7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Registered EXE slot
    logic              valid_q,   valid_d;
    logic [REG_W-1:0]  src1_q,    src1_d;
    logic [REG_W-1:0]  src2_q,    src2_d;
    logic [REG_W-1:0]  dest_q,    dest_d;
    logic [8:0]        ctrl_q,    ctrl_d;
    logic [DATA_W-1:0] pc_q,      pc_d;
    logic [DATA_W-1:0] val_rn_q,  val_rn_d;
    logic [DATA_W-1:0] val_rm_q,  val_rm_d;
    logic [36:0]       imm_q,     imm_d;
    logic [CNT_W-1:0]  stall_q,   stall_d;

    logic match_src1;
    logic match_src2;
    logic bubble;

    // A source conflicts with the instruction in EXE when that instruction
    // writes back and its result is not yet forwardable: always for loads,
    // and for any writer when forwarding is off. Without forwarding, a pending
    // write-back in MEM also conflicts. Indices compare over the full width,
    // so R15 behaves like any other register.
    function automatic logic src_match(
        input logic [REG_W-1:0] s,
        input logic             fwd_en,
        input logic             ex_valid,
        input logic [REG_W-1:0] ex_dest,
        input logic [8:0]       ex_ctrl,
        input logic             mm_wb_en,
        input logic [REG_W-1:0] mm_dest
    );
        logic exe_hit;
        logic mem_hit;
        exe_hit = (s == ex_dest) && ex_valid && ex_ctrl[CTRL_WB_EN] &&
                  (ex_ctrl[CTRL_MEM_R_EN] || !fwd_en);
        mem_hit = !fwd_en && mm_wb_en && (s == mm_dest);
        return exe_hit || mem_hit;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // Hazard detection against the EXE and MEM destinations; independent of freeze
    always_comb begin
        match_src1 = src_match(id_src1, forward_EN, valid_q, dest_q, ctrl_q,
                               mem_wb_en, mem_dest);
        match_src2 = src_match(id_src2, forward_EN, valid_q, dest_q, ctrl_q,
                               mem_wb_en, mem_dest);
        hazard     = id_valid && (match_src1 || (id_two_src && match_src2));
        bubble     = flush || hazard;
    end

    // Next-state selection with priority freeze > flush > hazard > load
    always_comb begin
        valid_d  = valid_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dest_d   = dest_q;
        ctrl_d   = ctrl_q;
        pc_d     = pc_q;
        val_rn_d = val_rn_q;
        val_rm_d = val_rm_q;
        imm_d    = imm_q;
        stall_d  = stall_q;

        if (!freeze) begin
            if (bubble) begin
                valid_d  = 1'b0;
                src1_d   = '0;
                src2_d   = '0;
                dest_d   = '0;
                ctrl_d   = '0;
                pc_d     = '0;
                val_rn_d = '0;
                val_rm_d = '0;
                imm_d    = '0;
            end else begin
                valid_d  = id_valid;
                src1_d   = id_src1;
                src2_d   = id_src2;
                dest_d   = id_dest;
                ctrl_d   = id_valid ? id_ctrl : 9'd0;
                pc_d     = id_pc;
                val_rn_d = id_val_rn;
                val_rm_d = id_val_rm;
                imm_d    = id_imm_fields;
            end

            // A flushed instruction is squashed, so its stall is not counted
            if (hazard && !flush) begin
                stall_d = sat_inc(stall_q);
            end
        end
    end

    // EXE slot and stall counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            dest_q   <= '0;
            ctrl_q   <= '0;
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
            imm_q    <= '0;
            stall_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dest_q   <= dest_d;
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            val_rn_q <= val_rn_d;
            val_rm_q <= val_rm_d;
            imm_q    <= imm_d;
            stall_q  <= stall_d;
        end
    end

    assign exe_valid      = valid_q;
    assign exe_src1       = src1_q;
    assign exe_src2       = src2_q;
    assign exe_dest       = dest_q;
    assign exe_ctrl       = ctrl_q;
    assign exe_pc         = pc_q;
    assign exe_val_rn     = val_rn_q;
    assign exe_val_rm     = val_rm_q;
    assign exe_imm_fields = imm_q;
    assign stall_count    = stall_q;

endmodule
